// File: rtl/step_counter.sv
// Prescaled up/down/ping-pong step counter with clear, saturating load, tick and wrap pulses.
// Ping-pong mode and its direction register exist only when STEP_COUNTER_PINGPONG_EN is defined.
module step_counter #(
  parameter int TICK_DIV = 50_000,
  parameter int CNT_W    = 8,
  parameter int CNT_MAX  = 255
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic [1:0]       mode,
  output logic [CNT_W-1:0] cnt_out,
  output logic             tick,
  output logic             wrap
);

  localparam int PS_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PS_W-1:0]  PS_LAST = PS_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] MAX_V   = CNT_W'(CNT_MAX);

  localparam logic [1:0] MODE_UP   = 2'b00;
  localparam logic [1:0] MODE_DOWN = 2'b01;
  localparam logic [1:0] MODE_PP   = 2'b10;

  logic [PS_W-1:0]  r_ps;
  logic [CNT_W-1:0] r_cnt;
  logic             r_tick;
  logic             r_wrap;

  logic [PS_W-1:0]  w_ps_next;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_tick_next;
  logic             w_wrap_next;
  logic             w_step;
  logic [CNT_W-1:0] w_inc_val;
  logic [CNT_W-1:0] w_dec_val;
  logic [CNT_W-1:0] w_load_sat;

`ifdef STEP_COUNTER_PINGPONG_EN
  typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_t;
  dir_t r_dir;
  dir_t w_dir_next;
`endif

  assign w_step     = en && (r_ps == PS_LAST);
  assign w_inc_val  = r_cnt + 1'b1;
  assign w_dec_val  = r_cnt - 1'b1;
  assign w_load_sat = (load_val > MAX_V) ? MAX_V : load_val;

  always_comb begin
    w_ps_next   = r_ps;
    w_cnt_next  = r_cnt;
    w_tick_next = 1'b0;
    w_wrap_next = 1'b0;
`ifdef STEP_COUNTER_PINGPONG_EN
    w_dir_next  = r_dir;
`endif
    if (clr) begin
      w_ps_next  = '0;
      w_cnt_next = '0;
`ifdef STEP_COUNTER_PINGPONG_EN
      w_dir_next = DIR_UP;
`endif
    end else begin
      if (en) begin
        w_ps_next = (r_ps == PS_LAST) ? '0 : r_ps + 1'b1;
      end
      if (load) begin
        w_cnt_next = w_load_sat;
      end else if (w_step) begin
        w_tick_next = 1'b1;
        case (mode)
          MODE_DOWN: begin
            w_cnt_next  = (r_cnt == '0) ? MAX_V : w_dec_val;
            w_wrap_next = (r_cnt == '0);
          end
`ifdef STEP_COUNTER_PINGPONG_EN
          MODE_PP: begin
            // An endpoint reached in another mode reverses before moving.
            if (r_dir == DIR_UP) begin
              if (r_cnt >= MAX_V) begin
                w_cnt_next  = w_dec_val;
                w_wrap_next = (w_dec_val == '0);
                w_dir_next  = (w_dec_val == '0) ? DIR_UP : DIR_DOWN;
              end else begin
                w_cnt_next  = w_inc_val;
                w_wrap_next = (w_inc_val == MAX_V);
                w_dir_next  = (w_inc_val == MAX_V) ? DIR_DOWN : DIR_UP;
              end
            end else begin
              if (r_cnt == '0) begin
                w_cnt_next  = w_inc_val;
                w_wrap_next = (w_inc_val == MAX_V);
                w_dir_next  = (w_inc_val == MAX_V) ? DIR_DOWN : DIR_UP;
              end else begin
                w_cnt_next  = w_dec_val;
                w_wrap_next = (w_dec_val == '0);
                w_dir_next  = (w_dec_val == '0) ? DIR_UP : DIR_DOWN;
              end
            end
          end
`else
          MODE_PP: begin
            w_cnt_next  = (r_cnt >= MAX_V) ? '0 : w_inc_val;
            w_wrap_next = (r_cnt >= MAX_V);
          end
`endif
          MODE_UP: begin
            w_cnt_next  = (r_cnt >= MAX_V) ? '0 : w_inc_val;
            w_wrap_next = (r_cnt >= MAX_V);
          end
          default: begin
            w_cnt_next = r_cnt;
          end
        endcase
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_ps   <= '0;
      r_cnt  <= '0;
      r_tick <= 1'b0;
      r_wrap <= 1'b0;
`ifdef STEP_COUNTER_PINGPONG_EN
      r_dir  <= DIR_UP;
`endif
    end else begin
      r_ps   <= w_ps_next;
      r_cnt  <= w_cnt_next;
      r_tick <= w_tick_next;
      r_wrap <= w_wrap_next;
`ifdef STEP_COUNTER_PINGPONG_EN
      r_dir  <= w_dir_next;
`endif
    end
  end

  assign cnt_out = r_cnt;
  assign tick    = r_tick;
  assign wrap    = r_wrap;

endmodule

// File: doc/step_counter.md
STEP_COUNTER -- requirements
Module: step_counter

Interface
REQ-001 SHALL have parameter TICK_DIV, default 50_000, giving sys_clk cycles per count step (1 ms at 50 MHz); legal range 1..2^24.
REQ-002 SHALL have parameter CNT_W, default 8, giving the count width; legal range 1..16.
REQ-003 SHALL have parameter CNT_MAX, default 255, giving the terminal count; legal range 1..2^CNT_W-1.
REQ-004 sys_clk  in  1  single clock, rising-edge active.
REQ-005 sys_rst_n  in  1  asynchronous, active-low reset.
REQ-006 en  in  1  high: prescaler and counter advance; low: both frozen.
REQ-007 clr  in  1  synchronous clear of prescaler, count and direction.
REQ-008 load  in  1  synchronous load of cnt_out from load_val.
REQ-009 load_val  in  CNT_W  value to load.
REQ-010 mode  in  2  00 up, 01 down, 10 ping-pong, 11 hold.
REQ-011 cnt_out  out  CNT_W  registered count.
REQ-012 tick  out  1  registered one-cycle pulse on every step.
REQ-013 wrap  out  1  registered one-cycle pulse on wrap or reversal.

Function
REQ-014 Prescaler width SHALL be clog2(TICK_DIV), minimum 1 bit; it SHALL count 0..TICK_DIV-1 while en=1 and return to 0 after TICK_DIV-1.
REQ-015 A step SHALL occur on the edge where en=1 and prescaler=TICK_DIV-1; with TICK_DIV=1, every enabled cycle SHALL be a step.
REQ-016 tick SHALL be 1 for exactly the cycle following a step edge, with cnt_out updated on that same edge (zero added latency).
REQ-017 Mode up SHALL increment cnt_out per step, taking CNT_MAX to 0 with wrap=1.
REQ-018 Mode down SHALL decrement cnt_out per step, taking 0 to CNT_MAX with wrap=1.
REQ-019 Mode ping-pong SHALL count up to CNT_MAX and then down to 0, repeating; wrap=1 on the step that reaches CNT_MAX and on the step that reaches 0.
REQ-020 Mode hold SHALL keep cnt_out unchanged; tick SHALL still pulse and wrap SHALL stay 0.
REQ-021 Priority SHALL be clr > load > step.
REQ-022 clr SHALL zero the prescaler and cnt_out, set direction to up, and force tick=0 and wrap=0 for that cycle.
REQ-023 load SHALL set cnt_out to load_val, or to CNT_MAX if load_val > CNT_MAX.
REQ-024 load SHALL leave the prescaler running and suppress any coinciding step; tick and wrap SHALL be 0 for that cycle.
REQ-025 If cnt_out > CNT_MAX cannot occur, no other saturation logic is needed.
REQ-026 A mode change SHALL take effect at the next step.
REQ-027 On entering ping-pong, direction SHALL be its stored value: up after reset or clr, otherwise the last ping-pong direction.
REQ-028 When en=0, tick and wrap SHALL be 0.

Reset
REQ-029 While sys_rst_n=0, prescaler SHALL be 0, cnt_out 0, tick 0, wrap 0, and direction up, independent of sys_clk.
REQ-030 Reset asserted mid-count SHALL discard the prescaler phase; the first step after release SHALL come TICK_DIV enabled cycles later.

Configuration
REQ-031 Macro STEP_COUNTER_PINGPONG_EN SHALL compile in ping-pong mode and its direction register.
REQ-032 Without STEP_COUNTER_PINGPONG_EN, mode 10 SHALL behave as mode 00 (up) and no direction register SHALL exist; all other behaviour is unchanged.

Verification (TICK_DIV=4, CNT_W=3, CNT_MAX=5 unless stated)
REQ-033 Up, en=1 held for 30 cycles -> tick every 4th cycle; cnt_out 0,1,2,3,4,5,0; wrap coincides with the 5->0 step.
REQ-034 Down from reset -> first step gives cnt_out=5 with wrap=1, then 4,3,...
REQ-035 Ping-pong with the macro defined -> 0..5..0..5; wrap at 5 and at 0. Without the macro -> same sequence as REQ-033.
REQ-036 load_val=7 with load=1, coinciding with a step -> cnt_out=5, tick=0; prescaler phase preserved, so the next tick comes 4 cycles later.
REQ-037 clr and load together mid-count at cnt_out=3 -> cnt_out=0, prescaler 0, next tick 4 enabled cycles later.
REQ-038 sys_rst_n pulsed low asynchronously mid-cycle -> all outputs 0 immediately; en toggling low freezes cnt_out and the prescaler with no tick.
